// File: rtl/wb_arb_pkg.sv
// Shared types for the register-bank write-back arbiter: default widths,
// requester ids, the hold-entry layout and a saturating counter helper.
package wb_arb_pkg;

  localparam int WIDTH_DEF  = 32;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_id_e;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [WIDTH_DEF-1:0]  data;
  } hold_ent_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/wb_hold_buf.sv
// One-entry valid/ready hold buffer; accepts on the same edge it is popped.
// Latency 1 cycle in -> out; ready is low while reset is asserted.
module wb_hold_buf
  import wb_arb_pkg::*;
#(
  parameter type ent_t = hold_ent_t
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_vld_i,
  input  ent_t in_dat_i,
  output logic in_rdy_o,
  input  logic pop_i,
  output logic out_vld_o,
  output ent_t out_dat_o
);

  logic vld_q, vld_d;
  ent_t dat_q, dat_d;

  always_comb begin
    in_rdy_o = !rst_i && (!vld_q || pop_i);
    vld_d    = vld_q;
    dat_d    = dat_q;
    if (pop_i) begin
      vld_d = 1'b0;
    end
    if (in_vld_i && in_rdy_o) begin
      vld_d = 1'b1;
      dat_d = in_dat_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign out_vld_o = vld_q;
  assign out_dat_o = dat_q;

endmodule

// File: rtl/reg_wb_arbiter.sv
// Round-robin write-back arbiter between ALU and MEM into a register bank.
// Transfer at edge k -> WE3 in cycle k+2; optional busy scoreboard under WB_SCOREBOARD_EN.
module reg_wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [1:0]             REQ_VALID,
  output logic [1:0]             REQ_READY,
  input  logic [2*ADDR_W-1:0]    REQ_ADDR,
  input  logic [2*WIDTH-1:0]     REQ_DATA,
  input  logic                   RSV_VALID,
  input  logic [ADDR_W-1:0]      RSV_ADDR,
  output logic                   WE3,
  output logic [ADDR_W-1:0]      RA3,
  output logic [WIDTH-1:0]       WD3,
  output logic                   GNT_ID,
  output logic [2**ADDR_W-1:0]   BUSY,
  output logic                   RSV_ERR,
  output logic [15:0]            STALL_CNT
);

  localparam int NREG = 2**ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
  } ent_t;

  ent_t       buf_in  [2];
  ent_t       buf_out [2];
  logic [1:0] buf_vld;
  logic [1:0] pop;

  for (genvar i = 0; i < 2; i++) begin : g_buf
    assign buf_in[i] = '{addr: REQ_ADDR[i*ADDR_W +: ADDR_W], data: REQ_DATA[i*WIDTH +: WIDTH]};

    wb_hold_buf #(.ent_t(ent_t)) u_hold (
      .clk_i     (CLK),
      .rst_i     (RST),
      .in_vld_i  (REQ_VALID[i]),
      .in_dat_i  (buf_in[i]),
      .in_rdy_o  (REQ_READY[i]),
      .pop_i     (pop[i]),
      .out_vld_o (buf_vld[i]),
      .out_dat_o (buf_out[i])
    );
  end

  logic              gnt_vld;
  req_id_e           gnt_id;
  req_id_e           rr_q, rr_d;
  logic [15:0]       stall_q, stall_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] ra_q, ra_d;
  logic [WIDTH-1:0]  wd_q, wd_d;
  req_id_e           gid_q, gid_d;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = REQ_ALU;
    pop     = '0;
    case (buf_vld)
      2'b01: begin
        gnt_vld = 1'b1;
        gnt_id  = REQ_ALU;
      end
      2'b10: begin
        gnt_vld = 1'b1;
        gnt_id  = REQ_MEM;
      end
      2'b11: begin
        gnt_vld = 1'b1;
        gnt_id  = rr_q;
      end
      default: ;
    endcase
    if (RST) begin
      gnt_vld = 1'b0;
    end
    if (gnt_vld) begin
      pop[gnt_id] = 1'b1;
    end
  end

  // The loser of a contended cycle gets priority next time both are full.
  always_comb begin
    rr_d    = gnt_vld ? req_id_e'(~gnt_id) : rr_q;
    stall_d = (&buf_vld && !RST) ? sat_inc16(stall_q) : stall_q;
    we_d    = gnt_vld;
    ra_d    = ra_q;
    wd_d    = wd_q;
    gid_d   = gid_q;
    if (gnt_vld) begin
      ra_d  = buf_out[gnt_id].addr;
      wd_d  = buf_out[gnt_id].data;
      gid_d = gnt_id;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_q    <= REQ_ALU;
      stall_q <= '0;
      we_q    <= 1'b0;
      ra_q    <= '0;
      wd_q    <= '0;
      gid_q   <= REQ_ALU;
    end else begin
      rr_q    <= rr_d;
      stall_q <= stall_d;
      we_q    <= we_d;
      ra_q    <= ra_d;
      wd_q    <= wd_d;
      gid_q   <= gid_d;
    end
  end

  assign WE3       = we_q;
  assign RA3       = ra_q;
  assign WD3       = wd_q;
  assign GNT_ID    = gid_q;
  assign STALL_CNT = stall_q;

`ifdef WB_SCOREBOARD_EN
  logic [NREG-1:0] busy_q, busy_d;
  logic            rsv_err_q, rsv_err_d;

  // Clear from the completing write is applied first so a same-cycle reserve wins.
  always_comb begin
    busy_d    = busy_q;
    rsv_err_d = RSV_VALID && busy_q[RSV_ADDR];
    if (we_q) begin
      busy_d[ra_q] = 1'b0;
    end
    if (RSV_VALID) begin
      busy_d[RSV_ADDR] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      busy_q    <= '0;
      rsv_err_q <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      rsv_err_q <= rsv_err_d;
    end
  end

  assign BUSY    = busy_q;
  assign RSV_ERR = rsv_err_q;
`else
  logic unused_rsv;
  assign unused_rsv = ^{RSV_VALID, RSV_ADDR};
  assign BUSY       = '0;
  assign RSV_ERR    = 1'b0;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: directed scenarios plus random traffic against a
// behavioural model of the hold buffers, round-robin grant and scoreboard.
module tb_reg_wb_arbiter;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 4;
  localparam int NREG   = 16;

  logic                 CLK = 1'b0;
  logic                 RST;
  logic [1:0]           REQ_VALID;
  logic [1:0]           REQ_READY;
  logic [2*ADDR_W-1:0]  REQ_ADDR;
  logic [2*WIDTH-1:0]   REQ_DATA;
  logic                 RSV_VALID;
  logic [ADDR_W-1:0]    RSV_ADDR;
  logic                 WE3;
  logic [ADDR_W-1:0]    RA3;
  logic [WIDTH-1:0]     WD3;
  logic                 GNT_ID;
  logic [NREG-1:0]      BUSY;
  logic                 RSV_ERR;
  logic [15:0]          STALL_CNT;

  reg_wb_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_ADDR  (REQ_ADDR),
    .REQ_DATA  (REQ_DATA),
    .RSV_VALID (RSV_VALID),
    .RSV_ADDR  (RSV_ADDR),
    .WE3       (WE3),
    .RA3       (RA3),
    .WD3       (WD3),
    .GNT_ID    (GNT_ID),
    .BUSY      (BUSY),
    .RSV_ERR   (RSV_ERR),
    .STALL_CNT (STALL_CNT)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: pending entries per requester, next expected bank write.
  bit        m_full [2];
  bit [3:0]  m_addr [2];
  bit [31:0] m_data [2];
  int        m_rr;
  bit        m_we;
  bit [3:0]  m_ra;
  bit [31:0] m_wd;
  bit        m_gid;
  int        m_stall;
  bit [15:0] m_busy;
  bit        m_err;
  int        wr_log[$];

  function automatic int m_pick();
    if (m_full[0] && m_full[1]) return m_rr;
    if (m_full[0]) return 0;
    if (m_full[1]) return 1;
    return -1;
  endfunction

  task automatic cyc(input bit rst, input bit [1:0] vld, input bit [3:0] a0, input bit [3:0] a1,
                     input bit [31:0] d0, input bit [31:0] d1, input bit rv, input bit [3:0] ra);
    int g;
    bit [1:0] rdy;
    RST       = rst;
    REQ_VALID = vld;
    REQ_ADDR  = {a1, a0};
    REQ_DATA  = {d1, d0};
    RSV_VALID = rv;
    RSV_ADDR  = ra;
    #1;
    g = rst ? -1 : m_pick();
    for (int i = 0; i < 2; i++) rdy[i] = !rst && (!m_full[i] || g == i);
    check_eq("ready", {30'd0, REQ_READY}, {30'd0, rdy});
    if (rst) begin
      m_full[0] = 0; m_full[1] = 0; m_rr = 0; m_we = 0; m_ra = 0; m_wd = 0;
      m_gid = 0; m_stall = 0; m_busy = 0; m_err = 0;
    end else begin
`ifdef WB_SCOREBOARD_EN
      m_err = rv && m_busy[ra];
      if (m_we) m_busy[m_ra] = 1'b0;
      if (rv) m_busy[ra] = 1'b1;
`endif
      if (m_full[0] && m_full[1] && m_stall < 65535) m_stall++;
      m_we = (g >= 0);
      if (g >= 0) begin
        m_ra = m_addr[g];
        m_wd = m_data[g];
        m_gid = g[0];
        m_rr = 1 - g;
        m_full[g] = 0;
      end
      for (int i = 0; i < 2; i++) begin
        if (vld[i] && rdy[i]) begin
          m_full[i] = 1;
          m_addr[i] = (i == 0) ? a0 : a1;
          m_data[i] = (i == 0) ? d0 : d1;
        end
      end
    end
    @(posedge CLK);
    @(negedge CLK);
    check_eq("we3", {31'd0, WE3}, {31'd0, m_we});
    if (m_we) begin
      check_eq("ra3", {28'd0, RA3}, {28'd0, m_ra});
      check_eq("wd3", WD3, m_wd);
      check_eq("gnt_id", {31'd0, GNT_ID}, {31'd0, m_gid});
    end
    check_eq("busy", {16'd0, BUSY}, {16'd0, m_busy});
    check_eq("rsv_err", {31'd0, RSV_ERR}, {31'd0, m_err});
    check_eq("stall_cnt", {16'd0, STALL_CNT}, m_stall);
    if (WE3 === 1'b1) wr_log.push_back(int'(GNT_ID));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 2'b00, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    cyc(1, 2'b00, 0, 0, 0, 0, 0, 0);
    cyc(1, 2'b00, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int n0;
    RST = 1'b1; REQ_VALID = '0; REQ_ADDR = '0; REQ_DATA = '0; RSV_VALID = 1'b0; RSV_ADDR = '0;
    @(negedge CLK);
    do_reset();
    check_eq("rst_we3", {31'd0, WE3}, 32'd0);
    check_eq("rst_ra3", {28'd0, RA3}, 32'd0);
    check_eq("rst_wd3", WD3, 32'd0);
    check_eq("rst_stall", {16'd0, STALL_CNT}, 32'd0);

    // Single uncontested write
    cyc(0, 2'b01, 4'd3, 0, 32'hDEADBEEF, 0, 0, 0);
    check_eq("single_c1_we3", {31'd0, WE3}, 32'd0);
    idle(1);
    check_eq("single_c2_we3", {31'd0, WE3}, 32'd1);
    check_eq("single_c2_ra3", {28'd0, RA3}, 32'd3);
    check_eq("single_c2_wd3", WD3, 32'hDEADBEEF);
    check_eq("single_c2_gnt", {31'd0, GNT_ID}, 32'd0);
    idle(1);
    check_eq("single_c3_we3", {31'd0, WE3}, 32'd0);
    check_eq("single_hold_wd3", WD3, 32'hDEADBEEF);

    // Contention
    do_reset();
    cyc(0, 2'b11, 4'd1, 4'd2, 32'd11, 32'd22, 0, 0);
    idle(1);
    check_eq("cont_c2_ra3", {28'd0, RA3}, 32'd1);
    check_eq("cont_c2_wd3", WD3, 32'd11);
    check_eq("cont_c2_gnt", {31'd0, GNT_ID}, 32'd0);
    idle(1);
    check_eq("cont_c3_we3", {31'd0, WE3}, 32'd1);
    check_eq("cont_c3_ra3", {28'd0, RA3}, 32'd2);
    check_eq("cont_c3_wd3", WD3, 32'd22);
    check_eq("cont_c3_gnt", {31'd0, GNT_ID}, 32'd1);
    check_eq("cont_stall", {16'd0, STALL_CNT}, 32'd1);
    idle(1);

    // Fairness: both held valid for 8 cycles
    do_reset();
    wr_log.delete();
    for (int k = 0; k < 8; k++)
      cyc(0, 2'b11, 4'($urandom), 4'($urandom), $urandom, $urandom, 0, 0);
    idle(4);
    check_eq("fair_nwrites_ge8", {31'd0, wr_log.size() >= 8}, 32'd1);
    n0 = 0;
    for (int k = 0; k < 8 && k < wr_log.size(); k++) begin
      check_eq("fair_order", wr_log[k], k % 2);
      if (wr_log[k] == 0) n0++;
    end
    check_eq("fair_alu_count", n0, 4);

    // Same destination register
    do_reset();
    cyc(0, 2'b11, 4'd5, 4'd5, 32'd5, 32'd9, 0, 0);
    idle(1);
    check_eq("same_c2_ra3", {28'd0, RA3}, 32'd5);
    check_eq("same_c2_wd3", WD3, 32'd5);
    idle(1);
    check_eq("same_c3_we3", {31'd0, WE3}, 32'd1);
    check_eq("same_c3_ra3", {28'd0, RA3}, 32'd5);
    check_eq("same_c3_wd3", WD3, 32'd9);

    // Reset with both buffers full
    do_reset();
    cyc(0, 2'b11, 4'd4, 4'd6, 32'hA5, 32'h5A, 0, 0);
    cyc(1, 2'b11, 4'd8, 4'd9, 32'h1, 32'h2, 0, 0);
    check_eq("mid_rst_we3", {31'd0, WE3}, 32'd0);
    check_eq("mid_rst_ra3", {28'd0, RA3}, 32'd0);
    check_eq("mid_rst_wd3", WD3, 32'd0);
    check_eq("mid_rst_gnt", {31'd0, GNT_ID}, 32'd0);
    check_eq("mid_rst_stall", {16'd0, STALL_CNT}, 32'd0);
    idle(1);
    check_eq("mid_rst_after1_we3", {31'd0, WE3}, 32'd0);
    idle(1);
    check_eq("mid_rst_after2_we3", {31'd0, WE3}, 32'd0);

`ifdef WB_SCOREBOARD_EN
    do_reset();
    cyc(0, 2'b00, 0, 0, 0, 0, 1, 4'd7);
    check_eq("sb_busy7", {31'd0, BUSY[7]}, 32'd1);
    check_eq("sb_no_err", {31'd0, RSV_ERR}, 32'd0);
    cyc(0, 2'b00, 0, 0, 0, 0, 1, 4'd7);
    check_eq("sb_err_pulse", {31'd0, RSV_ERR}, 32'd1);
    idle(1);
    check_eq("sb_err_clear", {31'd0, RSV_ERR}, 32'd0);
    cyc(0, 2'b01, 4'd7, 0, 32'h77, 0, 0, 0);
    idle(1);
    check_eq("sb_wr7_we3", {31'd0, WE3}, 32'd1);
    cyc(0, 2'b00, 0, 0, 0, 0, 1, 4'd7);
    check_eq("sb_set_wins", {31'd0, BUSY[7]}, 32'd1);
    idle(2);
`endif

    // Random traffic
    do_reset();
    for (int k = 0; k < 600; k++) begin
      cyc(($urandom % 64) == 0, 2'($urandom), 4'($urandom), 4'($urandom), $urandom, $urandom,
          ($urandom % 4) == 0, 4'($urandom));
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
